// File: rtl/dmem_pkg.sv
// Shared types and constants for the image data memory arbiter.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        INFER   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_NN   = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Owner-tag shift register that follows each read through the DMEM latency
// and raises the matching rvalid when the data comes back.
module dmem_rd_tag_pipe
    import dmem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  owner_t tag_i,
    output logic   host_rvalid_o,
    output logic   nn_rvalid_o
);

    owner_t tag_q [MEM_LAT];

    // Reset drops every read still in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= OWN_NONE;
            end
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign host_rvalid_o = (tag_q[MEM_LAT-1] == OWN_HOST);
    assign nn_rvalid_o   = (tag_q[MEM_LAT-1] == OWN_NN);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM owner: capture writes always win, host and NN share the
// rest round-robin, and a small FSM sequences capture -> inference -> idle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              pxlclk,
    input  logic              rst,
    input  logic              cap_wren,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              cap_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              nn_req,
    input  logic [ADDR_W-1:0] nn_addr,
    output logic              nn_gnt,
    output logic              nn_rvalid,
    output logic [DATA_W-1:0] nn_rdata,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic              ovr_clr,
    output logic              frame_ovr,
    output logic [1:0]        busy_state,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state_q, state_d;
    logic   rr_q, rr_d;          // 0: host has priority, 1: nn has priority
    logic   ovr_q, ovr_d;
    logic   start_q, start_d;
    owner_t tag_d;
    logic   nn_ok;

    assign nn_ok = nn_req && (state_q == INFER);

    always_comb begin
        host_gnt  = 1'b0;
        nn_gnt    = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_d     = OWN_NONE;
        rr_d      = rr_q;
        if (!rst) begin
            if (cap_wren) begin
                mem_wren  = 1'b1;
                mem_addr  = cap_addr;
                mem_wdata = cap_data;
            end else if (host_req && (!nn_ok || !rr_q)) begin
                host_gnt  = 1'b1;
                mem_wren  = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_we ? host_wdata : '0;
                tag_d     = host_we ? OWN_NONE : OWN_HOST;
                rr_d      = 1'b1;
            end else if (nn_ok) begin
                nn_gnt    = 1'b1;
                mem_addr  = nn_addr;
                tag_d     = OWN_NN;
                rr_d      = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_wren) state_d = CAPTURE;
            CAPTURE: if (cap_done) state_d = INFER;
            INFER:   if (nn_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Overrun set beats a simultaneous clear so no overwrite goes unreported.
    assign ovr_d   = (cap_wren && (state_q == INFER)) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
    assign start_d = (state_q == CAPTURE) && cap_done;

    always_ff @(posedge pxlclk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            ovr_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ovr_q   <= ovr_d;
            start_q <= start_d;
        end
    end

    dmem_rd_tag_pipe #(
        .MEM_LAT(MEM_LAT)
    ) u_tag_pipe (
        .clk_i         (pxlclk),
        .rst_i         (rst),
        .tag_i         (tag_d),
        .host_rvalid_o (host_rvalid),
        .nn_rvalid_o   (nn_rvalid)
    );

    assign host_rdata = host_rvalid ? mem_rdata : '0;
    assign nn_rdata   = nn_rvalid   ? mem_rdata : '0;
    assign nn_start   = start_q;
    assign frame_ovr  = ovr_q;
    assign busy_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one MEM_LAT=1 instance for the main flows
// and a MEM_LAT=2 instance sharing the same stimulus for latency and reset.
module tb_dmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         cap_wren, cap_done, host_req, host_we, nn_req, nn_done, ovr_clr;
    logic [6:0]   cap_addr, host_addr, nn_addr;
    logic [255:0] cap_data, host_wdata;

    logic         host_gnt, host_rvalid, nn_gnt, nn_rvalid, nn_start, frame_ovr, mem_wren;
    logic [255:0] host_rdata, nn_rdata, mem_wdata, rd1;
    logic [6:0]   mem_addr;
    logic [1:0]   busy_state;

    logic         host_gnt2, host_rvalid2, nn_gnt2, nn_rvalid2, nn_start2, frame_ovr2, mem_wren2;
    logic [255:0] host_rdata2, nn_rdata2, mem_wdata2, rd2a, rd2;
    logic [6:0]   mem_addr2;
    logic [1:0]   busy_state2;

    logic [255:0] mem [128];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        rd1  <= mem[mem_addr];
        rd2a <= mem[mem_addr2];
        rd2  <= rd2a;
    end

    dmem_arbiter #(.ADDR_W(7), .DATA_W(256), .MEM_LAT(1)) dut (
        .pxlclk(clk), .rst(rst), .cap_wren(cap_wren), .cap_addr(cap_addr), .cap_data(cap_data),
        .cap_done(cap_done), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .nn_req(nn_req), .nn_addr(nn_addr), .nn_gnt(nn_gnt),
        .nn_rvalid(nn_rvalid), .nn_rdata(nn_rdata), .nn_start(nn_start), .nn_done(nn_done),
        .ovr_clr(ovr_clr), .frame_ovr(frame_ovr), .busy_state(busy_state), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rd1)
    );

    dmem_arbiter #(.ADDR_W(7), .DATA_W(256), .MEM_LAT(2)) dut2 (
        .pxlclk(clk), .rst(rst), .cap_wren(cap_wren), .cap_addr(cap_addr), .cap_data(cap_data),
        .cap_done(cap_done), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt2), .host_rvalid(host_rvalid2),
        .host_rdata(host_rdata2), .nn_req(nn_req), .nn_addr(nn_addr), .nn_gnt(nn_gnt2),
        .nn_rvalid(nn_rvalid2), .nn_rdata(nn_rdata2), .nn_start(nn_start2), .nn_done(nn_done),
        .ovr_clr(ovr_clr), .frame_ovr(frame_ovr2), .busy_state(busy_state2), .mem_wren(mem_wren2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(rd2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cap_wren = 0; cap_done = 0; host_req = 0; host_we = 0; nn_req = 0;
        nn_done = 0; ovr_clr = 0; cap_addr = '0; host_addr = '0; nn_addr = '0;
        cap_data = '0; host_wdata = '0;
    endtask

    function automatic logic [255:0] pat(input int a);
        logic [15:0] w;
        w = 16'(a);
        return {16{w}};
    endfunction

    task automatic test_reset();
        rst = 1; host_req = 1; cap_wren = 1; cap_addr = 7'd3; nn_req = 1;
        #1;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL rst_host_gnt: got %b want 0", host_gnt); end
        checks++; if (nn_gnt !== 1'b0) begin errors++; $display("FAIL rst_nn_gnt: got %b want 0", nn_gnt); end
        checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rst_mem_wren: got %b want 0", mem_wren); end
        tick(); tick();
        rst = 0; clear_inputs();
        #1;
        checks++; if (busy_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", busy_state); end
        checks++; if (nn_start !== 1'b0) begin errors++; $display("FAIL rst_nn_start: got %b want 0", nn_start); end
        checks++; if (frame_ovr !== 1'b0) begin errors++; $display("FAIL rst_frame_ovr: got %b want 0", frame_ovr); end
        checks++; if (host_rvalid !== 1'b0 || nn_rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_rvalid: got host=%b nn=%b want 0/0", host_rvalid, nn_rvalid); end
        checks++; if (host_rdata !== '0) begin errors++; $display("FAIL rst_host_rdata: got %h want 0", host_rdata); end
    endtask

    task automatic test_frame_flow();
        for (int a = 0; a < 49; a++) begin
            cap_wren = 1; cap_addr = 7'(a); cap_data = pat(a);
            tick();
            if (a == 0) begin
                checks++; if (busy_state !== 2'd1) begin errors++; $display("FAIL frame_capture_state: got %0d want 1", busy_state); end
            end
        end
        cap_wren = 0; cap_done = 1;
        #1;
        checks++; if (busy_state !== 2'd1) begin errors++; $display("FAIL frame_pre_done_state: got %0d want 1", busy_state); end
        tick(); cap_done = 0;
        checks++; if (busy_state !== 2'd2) begin errors++; $display("FAIL frame_infer_state: got %0d want 2", busy_state); end
        checks++; if (nn_start !== 1'b1) begin errors++; $display("FAIL frame_nn_start: got %b want 1", nn_start); end
        tick();
        checks++; if (nn_start !== 1'b0) begin errors++; $display("FAIL frame_nn_start_pulse: got %b want 0", nn_start); end
        nn_req = 1; nn_addr = 7'd48;
        #1;
        checks++; if (nn_gnt !== 1'b1 || mem_addr !== 7'd48 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL frame_nn_gnt: got gnt=%b addr=%0d wren=%b want 1/48/0", nn_gnt, mem_addr, mem_wren); end
        tick(); nn_req = 0;
        checks++; if (nn_rvalid !== 1'b1 || nn_rdata !== pat(48)) begin
            errors++; $display("FAIL frame_nn_read: got v=%b d=%h want 1/%h", nn_rvalid, nn_rdata, pat(48)); end
        checks++; if (host_rvalid !== 1'b0 || host_rdata !== '0) begin
            errors++; $display("FAIL frame_host_idle: got v=%b d=%h want 0/0", host_rvalid, host_rdata); end
        tick();
        checks++; if (nn_rvalid !== 1'b0) begin errors++; $display("FAIL frame_nn_rvalid_drop: got %b want 0", nn_rvalid); end
        nn_done = 1; tick(); nn_done = 0;
        checks++; if (busy_state !== 2'd0) begin errors++; $display("FAIL frame_back_idle: got %0d want 0", busy_state); end
    endtask

    task automatic test_contention();
        logic eh [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic en [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic ph, pn;
        cap_wren = 1; cap_addr = 7'd100; cap_data = '0; tick();
        cap_wren = 0; cap_done = 1; tick(); cap_done = 0;
        checks++; if (busy_state !== 2'd2) begin errors++; $display("FAIL cont_state: got %0d want 2", busy_state); end
        host_req = 1; host_we = 0; host_addr = 7'd5; nn_req = 1; nn_addr = 7'd6;
        ph = 0; pn = 0;
        for (int i = 0; i < 6; i++) begin
            cap_wren = (i == 4); cap_addr = 7'd77;
            #1;
            checks++; if (host_gnt !== eh[i] || nn_gnt !== en[i]) begin
                errors++; $display("FAIL cont_gnt[%0d]: got h=%b n=%b want h=%b n=%b", i, host_gnt, nn_gnt, eh[i], en[i]); end
            checks++; if (host_rvalid !== ph || nn_rvalid !== pn) begin
                errors++; $display("FAIL cont_rvalid[%0d]: got h=%b n=%b want h=%b n=%b", i, host_rvalid, nn_rvalid, ph, pn); end
            if (i == 4) begin
                checks++; if (mem_wren !== 1'b1 || mem_addr !== 7'd77) begin
                    errors++; $display("FAIL cont_cap_mux: got wren=%b addr=%0d want 1/77", mem_wren, mem_addr); end
            end
            ph = eh[i]; pn = en[i];
            tick();
        end
        clear_inputs();
        ovr_clr = 1; tick(); ovr_clr = 0;
        checks++; if (frame_ovr !== 1'b0) begin errors++; $display("FAIL cont_ovr_clr: got %b want 0", frame_ovr); end
        nn_done = 1; tick(); nn_done = 0;
    endtask

    task automatic test_nn_gating();
        host_req = 1; host_we = 0; host_addr = 7'd4; nn_req = 1; nn_addr = 7'd3;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (nn_gnt !== 1'b0 || host_gnt !== 1'b1) begin
                errors++; $display("FAIL gate_idle[%0d]: got n=%b h=%b want 0/1", i, nn_gnt, host_gnt); end
            tick();
        end
        cap_wren = 1; cap_addr = 7'd120; cap_data = '0;
        #1;
        checks++; if (nn_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            errors++; $display("FAIL gate_cap_cycle: got n=%b h=%b want 0/0", nn_gnt, host_gnt); end
        tick(); cap_wren = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (nn_gnt !== 1'b0 || host_gnt !== 1'b1 || busy_state !== 2'd1) begin
                errors++; $display("FAIL gate_capture[%0d]: got n=%b h=%b st=%0d want 0/1/1", i, nn_gnt, host_gnt, busy_state); end
            tick();
        end
        clear_inputs();
        cap_done = 1; tick(); cap_done = 0;
        nn_done = 1; tick(); nn_done = 0;
        checks++; if (busy_state !== 2'd0) begin errors++; $display("FAIL gate_back_idle: got %0d want 0", busy_state); end
    endtask

    task automatic test_overrun();
        logic [255:0] d;
        d = {8{32'hA5A5_0F0F}};
        cap_wren = 1; cap_addr = 7'd20; tick();
        cap_wren = 0; cap_done = 1; tick(); cap_done = 0;
        checks++; if (busy_state !== 2'd2 || frame_ovr !== 1'b0) begin
            errors++; $display("FAIL ovr_pre: got st=%0d ovr=%b want 2/0", busy_state, frame_ovr); end
        cap_wren = 1; cap_addr = 7'd90; cap_data = d;
        #1;
        checks++; if (mem_wren !== 1'b1 || mem_addr !== 7'd90 || mem_wdata !== d) begin
            errors++; $display("FAIL ovr_write: got wren=%b addr=%0d data=%h want 1/90/%h", mem_wren, mem_addr, mem_wdata, d); end
        tick(); cap_wren = 0;
        checks++; if (frame_ovr !== 1'b1 || busy_state !== 2'd2) begin
            errors++; $display("FAIL ovr_set: got ovr=%b st=%0d want 1/2", frame_ovr, busy_state); end
        cap_wren = 1; cap_addr = 7'd91; ovr_clr = 1; tick(); cap_wren = 0;
        checks++; if (frame_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b want 1", frame_ovr); end
        tick(); ovr_clr = 0;
        checks++; if (frame_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", frame_ovr); end
        host_req = 1; host_we = 1; host_addr = 7'd95; host_wdata = ~d;
        #1;
        checks++; if (host_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_addr !== 7'd95 || mem_wdata !== ~d) begin
            errors++; $display("FAIL ovr_host_write: got g=%b w=%b a=%0d d=%h want 1/1/95/%h", host_gnt, mem_wren, mem_addr, mem_wdata, ~d); end
        tick(); clear_inputs();
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL ovr_write_no_rvalid: got %b want 0", host_rvalid); end
        nn_done = 1; tick(); nn_done = 0;
        checks++; if (busy_state !== 2'd0) begin errors++; $display("FAIL ovr_back_idle: got %0d want 0", busy_state); end
    endtask

    task automatic test_same_cycle();
        logic [255:0] d;
        d = {4{64'h0123_4567_89AB_CDEF}};
        cap_done = 1; tick(); cap_done = 0;
        checks++; if (busy_state !== 2'd0 || nn_start !== 1'b0) begin
            errors++; $display("FAIL same_done_idle: got st=%0d start=%b want 0/0", busy_state, nn_start); end
        cap_wren = 1; cap_addr = 7'd59; cap_data = '0; tick();
        cap_addr = 7'd60; cap_data = d; cap_done = 1;
        #1;
        checks++; if (mem_wren !== 1'b1 || mem_addr !== 7'd60) begin
            errors++; $display("FAIL same_wr_done_write: got wren=%b addr=%0d want 1/60", mem_wren, mem_addr); end
        tick(); clear_inputs();
        checks++; if (busy_state !== 2'd2 || nn_start !== 1'b1) begin
            errors++; $display("FAIL same_wr_done_state: got st=%0d start=%b want 2/1", busy_state, nn_start); end
        host_req = 1; host_we = 0; host_addr = 7'd60;
        #1;
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL same_host_gnt: got %b want 1", host_gnt); end
        tick(); host_req = 0;
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== d || nn_rdata !== '0) begin
            errors++; $display("FAIL same_readback: got v=%b d=%h want 1/%h", host_rvalid, host_rdata, d); end
        nn_done = 1; tick(); nn_done = 0;
        checks++; if (busy_state !== 2'd0) begin errors++; $display("FAIL same_back_idle: got %0d want 0", busy_state); end
    endtask

    task automatic test_lat2_reset();
        host_req = 1; host_we = 0; host_addr = 7'd10;
        #1;
        checks++; if (host_gnt2 !== 1'b1) begin errors++; $display("FAIL lat2_gnt: got %b want 1", host_gnt2); end
        tick(); host_req = 0;
        checks++; if (host_rvalid2 !== 1'b0) begin errors++; $display("FAIL lat2_early: got %b want 0", host_rvalid2); end
        tick();
        checks++; if (host_rvalid2 !== 1'b1 || host_rdata2 !== pat(10)) begin
            errors++; $display("FAIL lat2_read: got v=%b d=%h want 1/%h", host_rvalid2, host_rdata2, pat(10)); end
        tick();
        checks++; if (host_rvalid2 !== 1'b0) begin errors++; $display("FAIL lat2_drop: got %b want 0", host_rvalid2); end
        cap_wren = 1; cap_addr = 7'd11; cap_data = pat(11); tick(); cap_wren = 0;
        checks++; if (busy_state2 !== 2'd1) begin errors++; $display("FAIL lat2_capture: got %0d want 1", busy_state2); end
        host_req = 1; host_addr = 7'd10; tick();
        rst = 1;
        #1;
        checks++; if (host_gnt2 !== 1'b0) begin errors++; $display("FAIL lat2_rst_gnt: got %b want 0", host_gnt2); end
        tick(); rst = 0; host_req = 0;
        checks++; if (busy_state2 !== 2'd0 || frame_ovr2 !== 1'b0 || nn_start2 !== 1'b0) begin
            errors++; $display("FAIL lat2_rst_state: got st=%0d ovr=%b start=%b want 0/0/0", busy_state2, frame_ovr2, nn_start2); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (host_rvalid2 !== 1'b0 || nn_rvalid2 !== 1'b0) begin
                errors++; $display("FAIL lat2_rst_rvalid[%0d]: got h=%b n=%b want 0/0", i, host_rvalid2, nn_rvalid2); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_frame_flow();
        test_contention();
        test_nn_gating();
        test_overrun();
        test_same_cycle();
        test_lat2_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
